ch_rr_sched: RTL and testbench

Five-entry request buffer with a round-robin issue scheduler. Requests are written into the lowest free entry. Each cycle the block offers the first valid entry at or after a rotating read pointer, circularly, to a single downstream consumer over a valid/ready handshake. Issued entries are freed, and the pointer advances past the issued entry so every occupied slot is served fairly. The block sits between request producers and a shared downstream pipeline.

---
 rtl/ch_rr_sched.sv | 125 ++++++++++++
 tb/tb_ch_rr_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ch_rr_sched.sv
// ch_rr_sched: five-entry request buffer with a round-robin issue scheduler.
// Producers write into the lowest free entry. A rotating read pointer picks
// which valid entry is offered downstream, and a stalled offer is held stable.

module ch_rr_sched #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   input  logic [DATA_W-1:0] alloc_data_i,
   output logic [2:0]        alloc_id_o,
   output logic              iss_valid_o,
   input  logic              iss_ready_i,
   output logic [DATA_W-1:0] iss_data_o,
   output logic [2:0]        iss_id_o,
   output logic [2:0]        count_o
);

   localparam int N = 5;

   logic [N-1:0]      entryValid_q, entryValid_d;
   logic [DATA_W-1:0] payload_q [N];
   logic [2:0]        rdPtr_q, rdPtr_d;
   logic              lock_q, lock_d;
   logic [2:0]        lockId_q, lockId_d;
   logic [2:0]        count_q, count_d;

   logic              anyValid;
   logic              allocHs;
   logic              issHs;
   logic [2:0]        allocId;
   logic [2:0]        searchId;
   logic [2:0]        sel;
   logic [2:0]        nextPtr;
   logic [3:0]        rotSum;

   // Lowest-index free entry; scanning downward lets the smallest index win.
   always_comb begin
      allocId = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!entryValid_q[i]) allocId = 3'(i);
      end
   end

   // First valid entry at or after the read pointer, wrapping mod 5.
   always_comb begin
      searchId = 3'd0;
      rotSum   = 4'd0;
      for (int k = N - 1; k >= 0; k--) begin
         rotSum = {1'b0, rdPtr_q} + 4'(k);
         if (rotSum >= 4'd5) rotSum = rotSum - 4'd5;
         if (entryValid_q[rotSum[2:0]]) searchId = rotSum[2:0];
      end
   end

   assign anyValid      = |entryValid_q;
   assign sel           = lock_q ? lockId_q : searchId;
   assign nextPtr       = (sel == 3'd4) ? 3'd0 : sel + 3'd1;

   assign alloc_ready_o = ~(&entryValid_q) & ~flush_i;
   assign alloc_id_o    = allocId;
   assign iss_valid_o   = anyValid & ~flush_i;
   assign iss_id_o      = sel;
   assign iss_data_o    = anyValid ? payload_q[sel] : '0;
   assign count_o       = count_q;

   assign allocHs       = alloc_valid_i & alloc_ready_o;
   assign issHs         = iss_valid_o & iss_ready_i;

   // Next-state: issue frees and advances, stall locks the offer, alloc fills.
   always_comb begin
      entryValid_d = entryValid_q;
      rdPtr_d      = rdPtr_q;
      lock_d       = lock_q;
      lockId_d     = lockId_q;
      count_d      = count_q;
      if (flush_i) begin
         entryValid_d = '0;
         rdPtr_d      = 3'd0;
         lock_d       = 1'b0;
         count_d      = 3'd0;
      end else begin
         if (issHs) begin
            entryValid_d[sel] = 1'b0;
            rdPtr_d           = nextPtr;
            lock_d            = 1'b0;
         end else if (iss_valid_o) begin
            lock_d   = 1'b1;
            lockId_d = sel;
         end
         if (allocHs) entryValid_d[allocId] = 1'b1;
         case ({allocHs, issHs})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Scheduler state register with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entryValid_q <= '0;
         rdPtr_q      <= 3'd0;
         lock_q       <= 1'b0;
         lockId_q     <= 3'd0;
         count_q      <= 3'd0;
      end else begin
         entryValid_q <= entryValid_d;
         rdPtr_q      <= rdPtr_d;
         lock_q       <= lock_d;
         lockId_q     <= lockId_d;
         count_q      <= count_d;
      end
   end

   // Payload storage is write-only on allocation and never cleared.
   always_ff @(posedge clk_i) begin
      if (allocHs) payload_q[allocId] <= alloc_data_i;
   end

endmodule

// File: tb/tb_ch_rr_sched.sv
// tb_ch_rr_sched: directed scenario tests for the round-robin request buffer.

module tb_ch_rr_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        alloc_valid_i = 1'b0;
   logic        alloc_ready_o;
   logic [31:0] alloc_data_i = '0;
   logic [2:0]  alloc_id_o;
   logic        iss_valid_o;
   logic        iss_ready_i = 1'b0;
   logic [31:0] iss_data_o;
   logic [2:0]  iss_id_o;
   logic [2:0]  count_o;

   int errCount = 0;
   int checkCount = 0;

   ch_rr_sched #(.DATA_W(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
      .alloc_data_i(alloc_data_i), .alloc_id_o(alloc_id_o),
      .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
      .iss_data_o(iss_data_o), .iss_id_o(iss_id_o), .count_o(count_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk_i = ~clk_i;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reset values with payload storage still uninitialised.
   task automatic test_reset();
      #3;
      checkCount++; if (alloc_ready_o !== 1'b1) begin errCount++; $display("[TB] FAIL reset_alloc_ready got %0b want 1", alloc_ready_o); end
      checkCount++; if (iss_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL reset_iss_valid got %0b want 0", iss_valid_o); end
      checkCount++; if (count_o !== 3'd0) begin errCount++; $display("[TB] FAIL reset_count got %0d want 0", count_o); end
      checkCount++; if (alloc_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL reset_alloc_id got %0d want 0", alloc_id_o); end
      checkCount++; if (iss_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL reset_iss_id got %0d want 0", iss_id_o); end
      checkCount++; if (iss_data_o !== 32'd0) begin errCount++; $display("[TB] FAIL reset_iss_data got %h want 0", iss_data_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   // Three allocations while stalled, then drain; leaves rd_ptr=3, empty.
   task automatic test_alloc_basic();
      logic [31:0] d [3];
      d[0] = 32'hA000_0001; d[1] = 32'hB000_0002; d[2] = 32'hC000_0003;
      iss_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alloc_valid_i = 1'b1; alloc_data_i = d[i]; #1;
         checkCount++; if (alloc_id_o !== 3'(i)) begin errCount++; $display("[TB] FAIL basic_alloc_id[%0d] got %0d want %0d", i, alloc_id_o, i); end
         if (i == 0) begin
            checkCount++; if (iss_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL basic_no_bypass got %0b want 0", iss_valid_o); end
         end else begin
            checkCount++; if (iss_valid_o !== 1'b1 || iss_id_o !== 3'd0 || iss_data_o !== d[0]) begin errCount++; $display("[TB] FAIL basic_offer[%0d] got v=%0b id=%0d data=%h want v=1 id=0 data=%h", i, iss_valid_o, iss_id_o, iss_data_o, d[0]); end
         end
         tick();
      end
      alloc_valid_i = 1'b0; #1;
      checkCount++; if (count_o !== 3'd3) begin errCount++; $display("[TB] FAIL basic_count got %0d want 3", count_o); end
      iss_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkCount++; if (iss_valid_o !== 1'b1 || iss_id_o !== 3'(i) || iss_data_o !== d[i] || count_o !== 3'(3 - i)) begin errCount++; $display("[TB] FAIL basic_drain[%0d] got v=%0b id=%0d data=%h cnt=%0d want v=1 id=%0d data=%h cnt=%0d", i, iss_valid_o, iss_id_o, iss_data_o, count_o, i, d[i], 3 - i); end
         tick();
      end
      checkCount++; if (iss_valid_o !== 1'b0 || count_o !== 3'd0) begin errCount++; $display("[TB] FAIL basic_empty got v=%0b cnt=%0d want v=0 cnt=0", iss_valid_o, count_o); end
      iss_ready_i = 1'b0;
   endtask

   // From rd_ptr=3: wrap search picks entry 0, stalled offer survives an
   // allocation landing at the pointer, then RR continues at entry 1.
   task automatic test_wrap_stability();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hD000_0010 + 32'(i);
      iss_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alloc_valid_i = 1'b1; alloc_data_i = d[i]; #1;
         checkCount++; if (alloc_id_o !== 3'(i)) begin errCount++; $display("[TB] FAIL wrap_alloc_id[%0d] got %0d want %0d", i, alloc_id_o, i); end
         if (i > 0) begin
            checkCount++; if (iss_valid_o !== 1'b1 || iss_id_o !== 3'd0 || iss_data_o !== d[0]) begin errCount++; $display("[TB] FAIL wrap_offer[%0d] got v=%0b id=%0d data=%h want v=1 id=0 data=%h", i, iss_valid_o, iss_id_o, iss_data_o, d[0]); end
         end
         tick();
      end
      alloc_valid_i = 1'b0; #1;
      checkCount++; if (iss_id_o !== 3'd0 || count_o !== 3'd4) begin errCount++; $display("[TB] FAIL stable_offer got id=%0d cnt=%0d want id=0 cnt=4", iss_id_o, count_o); end
      iss_ready_i = 1'b1;
      tick();
      for (int i = 1; i < 4; i++) begin
         #1;
         checkCount++; if (iss_id_o !== 3'(i) || iss_data_o !== d[i] || count_o !== 3'(4 - i)) begin errCount++; $display("[TB] FAIL wrap_next[%0d] got id=%0d data=%h cnt=%0d want id=%0d data=%h cnt=%0d", i, iss_id_o, iss_data_o, count_o, i, d[i], 4 - i); end
         tick();
      end
      checkCount++; if (iss_valid_o !== 1'b0) begin errCount++; $display("[TB] FAIL wrap_empty got v=%0b want 0", iss_valid_o); end
      iss_ready_i = 1'b0;
   endtask

   // Flush while stalled on entry 1 with an alloc and ready both requested.
   task automatic test_flush();
      alloc_valid_i = 1'b1; alloc_data_i = 32'hE000_0000; iss_ready_i = 1'b1; #1;
      checkCount++; if (alloc_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL flush_setup_id got %0d want 0", alloc_id_o); end
      tick();
      alloc_data_i = 32'hE000_0001; #1;
      checkCount++; if (iss_id_o !== 3'd0 || alloc_id_o !== 3'd1) begin errCount++; $display("[TB] FAIL flush_setup_a got iss=%0d alloc=%0d want iss=0 alloc=1", iss_id_o, alloc_id_o); end
      tick();
      iss_ready_i = 1'b0; alloc_data_i = 32'hE000_0002; #1;
      checkCount++; if (iss_id_o !== 3'd1 || iss_data_o !== 32'hE000_0001 || alloc_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL flush_setup_b got iss=%0d data=%h alloc=%0d want iss=1 data=e0000001 alloc=0", iss_id_o, iss_data_o, alloc_id_o); end
      tick();
      flush_i = 1'b1; iss_ready_i = 1'b1; alloc_data_i = 32'hE000_0003; #1;
      checkCount++; if (iss_valid_o !== 1'b0 || alloc_ready_o !== 1'b0 || count_o !== 3'd2) begin errCount++; $display("[TB] FAIL flush_cycle got v=%0b rdy=%0b cnt=%0d want v=0 rdy=0 cnt=2", iss_valid_o, alloc_ready_o, count_o); end
      tick();
      flush_i = 1'b0; alloc_valid_i = 1'b0; iss_ready_i = 1'b0; #1;
      checkCount++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0 || alloc_ready_o !== 1'b1 || alloc_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL flush_after got cnt=%0d v=%0b rdy=%0b id=%0d want cnt=0 v=0 rdy=1 id=0", count_o, iss_valid_o, alloc_ready_o, alloc_id_o); end
   endtask

   // Fill 0..4 then drain in strict 0..4 order; rd_ptr wraps back to 0.
   task automatic test_rr_fairness();
      logic [31:0] d [5];
      for (int i = 0; i < 5; i++) d[i] = 32'hF000_0100 + 32'(i);
      iss_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         alloc_valid_i = 1'b1; alloc_data_i = d[i]; #1;
         checkCount++; if (alloc_id_o !== 3'(i)) begin errCount++; $display("[TB] FAIL rr_alloc_id[%0d] got %0d want %0d", i, alloc_id_o, i); end
         if (i > 0) begin
            checkCount++; if (iss_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL rr_fill_offer[%0d] got %0d want 0", i, iss_id_o); end
         end
         tick();
      end
      alloc_valid_i = 1'b0; #1;
      checkCount++; if (count_o !== 3'd5 || alloc_ready_o !== 1'b0) begin errCount++; $display("[TB] FAIL rr_full got cnt=%0d rdy=%0b want cnt=5 rdy=0", count_o, alloc_ready_o); end
      iss_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkCount++; if (iss_valid_o !== 1'b1 || iss_id_o !== 3'(i) || iss_data_o !== d[i] || count_o !== 3'(5 - i)) begin errCount++; $display("[TB] FAIL rr_issue[%0d] got v=%0b id=%0d data=%h cnt=%0d want v=1 id=%0d data=%h cnt=%0d", i, iss_valid_o, iss_id_o, iss_data_o, count_o, i, d[i], 5 - i); end
         tick();
      end
      checkCount++; if (iss_valid_o !== 1'b0 || count_o !== 3'd0) begin errCount++; $display("[TB] FAIL rr_empty got v=%0b cnt=%0d want v=0 cnt=0", iss_valid_o, count_o); end
      iss_ready_i = 1'b0;
   endtask

   // Full buffer with concurrent issue, then concurrent alloc+issue, then
   // an asynchronous reset while the offer on entry 2 is stalled.
   task automatic test_back_to_back();
      logic [31:0] d [7];
      for (int i = 0; i < 7; i++) d[i] = 32'h1200_0000 + 32'(i);
      iss_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         alloc_valid_i = 1'b1; alloc_data_i = d[i]; #1;
         checkCount++; if (alloc_id_o !== 3'(i)) begin errCount++; $display("[TB] FAIL b2b_alloc_id[%0d] got %0d want %0d", i, alloc_id_o, i); end
         tick();
      end
      alloc_data_i = d[5]; iss_ready_i = 1'b1; #1;
      checkCount++; if (alloc_ready_o !== 1'b0 || count_o !== 3'd5 || iss_id_o !== 3'd0) begin errCount++; $display("[TB] FAIL full_concurrent got rdy=%0b cnt=%0d id=%0d want rdy=0 cnt=5 id=0", alloc_ready_o, count_o, iss_id_o); end
      tick();
      #1;
      checkCount++; if (alloc_ready_o !== 1'b1 || alloc_id_o !== 3'd0 || iss_id_o !== 3'd1 || iss_data_o !== d[1] || count_o !== 3'd4) begin errCount++; $display("[TB] FAIL freed_reuse got rdy=%0b aid=%0d iid=%0d data=%h cnt=%0d want rdy=1 aid=0 iid=1 data=%h cnt=4", alloc_ready_o, alloc_id_o, iss_id_o, iss_data_o, count_o, d[1]); end
      tick();
      alloc_valid_i = 1'b0; iss_ready_i = 1'b0; #1;
      checkCount++; if (count_o !== 3'd4 || alloc_id_o !== 3'd1 || iss_id_o !== 3'd2 || iss_data_o !== d[2]) begin errCount++; $display("[TB] FAIL alloc_issue_same got cnt=%0d aid=%0d iid=%0d data=%h want cnt=4 aid=1 iid=2 data=%h", count_o, alloc_id_o, iss_id_o, iss_data_o, d[2]); end
      tick();
      #1;
      checkCount++; if (iss_id_o !== 3'd2 || iss_valid_o !== 1'b1) begin errCount++; $display("[TB] FAIL pre_reset_stall got id=%0d v=%0b want id=2 v=1", iss_id_o, iss_valid_o); end
      #2;
      rst_ni = 1'b0; #1;
      checkCount++; if (alloc_ready_o !== 1'b1 || iss_valid_o !== 1'b0 || count_o !== 3'd0) begin errCount++; $display("[TB] FAIL async_reset_a got rdy=%0b v=%0b cnt=%0d want rdy=1 v=0 cnt=0", alloc_ready_o, iss_valid_o, count_o); end
      checkCount++; if (alloc_id_o !== 3'd0 || iss_id_o !== 3'd0 || iss_data_o !== 32'd0) begin errCount++; $display("[TB] FAIL async_reset_b got aid=%0d iid=%0d data=%h want 0 0 0", alloc_id_o, iss_id_o, iss_data_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      alloc_valid_i = 1'b1; alloc_data_i = d[6];
      tick();
      alloc_valid_i = 1'b0; #1;
      checkCount++; if (iss_valid_o !== 1'b1 || iss_id_o !== 3'd0 || iss_data_o !== d[6] || count_o !== 3'd1) begin errCount++; $display("[TB] FAIL post_reset got v=%0b id=%0d data=%h cnt=%0d want v=1 id=0 data=%h cnt=1", iss_valid_o, iss_id_o, iss_data_o, count_o, d[6]); end
   endtask

   // Scenario sequence; each task leaves the state the next one expects.
   initial begin
      test_reset();
      test_alloc_basic();
      test_wrap_stability();
      test_flush();
      test_rr_fairness();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
